// File: rtl/branch_predict_unit_pkg.sv
// Shared LEGv8 branch-decode constants for branch_predict_unit and cond_eval.
// The opcode-field width macros mirror opcode.vh so this slice elaborates on its own.
`ifndef OPCODESIZE
`define OPCODESIZE 11
`endif
`ifndef REGADDRSIZE
`define REGADDRSIZE 5
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif

package branch_predict_unit_pkg;

    // B.cond condition codes, evaluated against NZVC
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam logic [`OPCODESIZE-1:0] B_MASK       = 11'b111111_00000;
    localparam logic [`OPCODESIZE-1:0] B_BITSET     = 11'b000101_00000;
    localparam logic [`OPCODESIZE-1:0] CB_MASK      = 11'b1111111_0000;
    localparam logic [`OPCODESIZE-1:0] CB_BITSET    = 11'b1011010_0000;
    localparam logic [`OPCODESIZE-1:0] BFLAG_MASK   = 11'b11111111_000;
    localparam logic [`OPCODESIZE-1:0] BFLAG_BITSET = 11'b01010100_000;

    // Weakly-not-taken: the value just below the taken threshold
    function automatic int unsigned ctr_reset_val(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing signals of branch_predict_unit.
// Stat outputs exist only when BRANCH_STATS_EN is defined.
interface branch_predict_unit_if #(
    parameter int PCWIDTH = 64
);
    logic                    f_valid;
    logic [PCWIDTH-1:0]      f_pc;
    logic                    p_valid;
    logic                    p_taken;
    logic                    x_valid;
    logic [PCWIDTH-1:0]      x_pc;
    logic [`OPCODESIZE-1:0]  x_opcode;
    logic [`REGADDRSIZE-1:0] x_rd;
    logic [`FLAGSIZE-1:0]    x_flags;
    logic                    x_zero;
    logic                    x_predicted;
    logic                    x_branch;
    logic                    mispredict;
    logic                    mispredict_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0]             stat_branches;
    logic [31:0]             stat_mispredicts;
`endif

    modport master (
        output f_valid, f_pc, x_valid, x_pc, x_opcode, x_rd, x_flags, x_zero, x_predicted,
        input  p_valid, p_taken, x_branch, mispredict, mispredict_taken
`ifdef BRANCH_STATS_EN
        , stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  f_valid, f_pc, x_valid, x_pc, x_opcode, x_rd, x_flags, x_zero, x_predicted,
        output p_valid, p_taken, x_branch, mispredict, mispredict_taken
`ifdef BRANCH_STATS_EN
        , stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predict_unit_cond_eval.sv
// cond_eval: NZVC flags plus B.cond condition code -> taken. Codes 0xE/0xF never taken.
module cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [`FLAGSIZE-1:0] flags,
    input  logic [3:0]           cond,
    output logic                 taken
);
    logic n, z, v, c;
    assign {n, z, v, c} = flags;

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_HS: taken = c;
            COND_LO: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~(c & ~z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = ~(~z & (n == v));
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve + PC-indexed saturating-counter predictor with registered mispredict.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PCWIDTH = 64,
    parameter int DEPTH   = 64,
    parameter int CTRBITS = 2
) (
    input logic clk,
    input logic rst,
    branch_predict_unit_if.slave bus
);
    localparam int IDXBITS = $clog2(DEPTH);
    localparam logic [CTRBITS-1:0] CTR_INIT = CTRBITS'(ctr_reset_val(CTRBITS));
    localparam logic [CTRBITS-1:0] CTR_MAX  = '1;
    localparam logic [CTRBITS-1:0] CTR_ONE  = CTRBITS'(1);

    logic [CTRBITS-1:0] ctr [DEPTH];

    logic [IDXBITS-1:0] f_idx, x_idx;
    logic [CTRBITS-1:0] x_ctr;
    logic [`OPCODESIZE-1:0] op;
    logic is_uncond, is_cbr, is_fbr, is_branch, cond_taken, taken_raw, x_branch;
    logic mispred_d, upd;
    logic vld_p1, taken_p1, mispred_p1, mispred_taken_p1;
    logic unused_bits;

    assign f_idx = bus.f_pc[IDXBITS+1:2];
    assign x_idx = bus.x_pc[IDXBITS+1:2];
    assign x_ctr = ctr[x_idx];
    assign op    = bus.x_opcode;

    // PC bits outside the index are deliberately aliased away
    assign unused_bits = ^{bus.f_pc[PCWIDTH-1:IDXBITS+2], bus.f_pc[1:0],
                           bus.x_pc[PCWIDTH-1:IDXBITS+2], bus.x_pc[1:0], bus.x_rd[4]};

    cond_eval u_cond_eval (
        .flags (bus.x_flags),
        .cond  (bus.x_rd[3:0]),
        .taken (cond_taken)
    );

    assign is_uncond = (op & B_MASK) == B_BITSET;
    assign is_cbr    = (op & CB_MASK) == CB_BITSET;
    assign is_fbr    = (op & BFLAG_MASK) == BFLAG_BITSET;
    assign is_branch = is_uncond | is_cbr | is_fbr;

    // opcode[3] separates CBNZ (1) from CBZ (0)
    assign taken_raw = is_uncond
                     | (is_cbr & ((~op[3] & bus.x_zero) | (op[3] & ~bus.x_zero)))
                     | (is_fbr & cond_taken);
    assign x_branch  = bus.x_valid & is_branch & taken_raw;
    assign upd       = bus.x_valid & is_branch;
    assign mispred_d = bus.x_valid & (x_branch != bus.x_predicted);

    // stage p1: prediction, table update, mispredict report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
            vld_p1           <= 1'b0;
            taken_p1         <= 1'b0;
            mispred_p1       <= 1'b0;
            mispred_taken_p1 <= 1'b0;
        end else begin
            vld_p1           <= bus.f_valid;
            taken_p1         <= bus.f_valid & ctr[f_idx][CTRBITS-1];
            mispred_p1       <= mispred_d;
            mispred_taken_p1 <= mispred_d & x_branch;
            if (upd) begin
                if (taken_raw) begin
                    if (x_ctr != CTR_MAX) ctr[x_idx] <= x_ctr + CTR_ONE;
                end else begin
                    if (x_ctr != '0) ctr[x_idx] <= x_ctr - CTR_ONE;
                end
            end
        end
    end

    assign bus.p_valid          = vld_p1;
    assign bus.p_taken          = taken_p1;
    assign bus.x_branch         = x_branch;
    assign bus.mispredict       = mispred_p1;
    assign bus.mispredict_taken = mispred_taken_p1;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_p1, stat_mp_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_p1 <= '0;
            stat_mp_p1 <= '0;
        end else begin
            if (upd && stat_br_p1 != '1)       stat_br_p1 <= stat_br_p1 + 32'd1;
            if (mispred_d && stat_mp_p1 != '1) stat_mp_p1 <= stat_mp_p1 + 32'd1;
        end
    end

    assign bus.stat_branches    = stat_br_p1;
    assign bus.stat_mispredicts = stat_mp_p1;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve vector table plus predict/reset sequences.
module tb_branch_predict_unit;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_BC   = 11'b01010100000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;

    typedef struct {
        logic        xv;
        logic [10:0] op;
        logic [4:0]  rd;
        logic [3:0]  flags;
        logic        zero;
        logic [63:0] pc;
        logic        pred;
        logic        e_br;
        logic        e_isbr;
        logic        e_mp;
        logic        e_mt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_br_cnt = 0;
    int   exp_mp_cnt = 0;
    vec_t vecs [15];

    branch_predict_unit_if #(.PCWIDTH(64)) bus ();

    branch_predict_unit #(.PCWIDTH(64), .DEPTH(64), .CTRBITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.f_valid = 1'b0; bus.f_pc = '0;
        bus.x_valid = 1'b0; bus.x_pc = '0; bus.x_opcode = '0; bus.x_rd = '0;
        bus.x_flags = '0; bus.x_zero = 1'b0; bus.x_predicted = 1'b0;
    endtask

    // Entered and left just after a rising edge
    task automatic resolve(input vec_t v, input string nm);
        bus.x_valid = v.xv; bus.x_opcode = v.op; bus.x_rd = v.rd; bus.x_flags = v.flags;
        bus.x_zero = v.zero; bus.x_pc = v.pc; bus.x_predicted = v.pred;
        #1;
        check({nm, ".x_branch"}, 32'(bus.x_branch), 32'(v.e_br));
        @(posedge clk); #1;
        if (v.xv && v.e_isbr) exp_br_cnt++;
        if (v.e_mp) exp_mp_cnt++;
        check({nm, ".mispredict"}, 32'(bus.mispredict), 32'(v.e_mp));
        check({nm, ".mispredict_taken"}, 32'(bus.mispredict_taken), 32'(v.e_mt));
        bus.x_valid = 1'b0; bus.x_predicted = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] pc, input logic exp_taken, input string nm);
        bus.f_valid = 1'b1; bus.f_pc = pc;
        @(posedge clk); #1;
        check({nm, ".p_valid"}, 32'(bus.p_valid), 32'd1);
        check({nm, ".p_taken"}, 32'(bus.p_taken), 32'(exp_taken));
        bus.f_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic xv, input logic [10:0] op, input logic [4:0] rd,
                                input logic [3:0] fl, input logic z, input logic [63:0] pc,
                                input logic pred, input logic br, input logic isbr,
                                input logic mp, input logic mt);
        vec_t v;
        v.xv = xv; v.op = op; v.rd = rd; v.flags = fl; v.zero = z; v.pc = pc; v.pred = pred;
        v.e_br = br; v.e_isbr = isbr; v.e_mp = mp; v.e_mt = mt;
        return v;
    endfunction

    initial begin
        //            xv  op       rd     NZVC   z  pc      pr br isb mp mt
        vecs[0]  = mk(1, OP_B,    5'h00, 4'h0, 0, 64'h40, 0, 1, 1, 1, 1);
        vecs[1]  = mk(1, OP_B,    5'h00, 4'h0, 0, 64'h40, 0, 1, 1, 1, 1);
        vecs[2]  = mk(1, OP_CBNZ, 5'h00, 4'h0, 0, 64'h80, 1, 1, 1, 0, 0);
        vecs[3]  = mk(1, OP_CBZ,  5'h00, 4'h0, 0, 64'h84, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, OP_CBZ,  5'h00, 4'h0, 1, 64'h88, 0, 1, 1, 1, 1);
        vecs[5]  = mk(1, OP_BC,   5'h0A, 4'h9, 0, 64'hC0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(1, OP_BC,   5'h0B, 4'h9, 0, 64'hC4, 0, 1, 1, 1, 1);
        vecs[7]  = mk(1, OP_BC,   5'h0E, 4'h0, 0, 64'hC8, 1, 0, 1, 1, 0);
        vecs[8]  = mk(1, OP_BC,   5'h0F, 4'hF, 0, 64'hCC, 0, 0, 1, 0, 0);
        vecs[9]  = mk(1, OP_BC,   5'h00, 4'h4, 0, 64'hD0, 1, 1, 1, 0, 0);
        vecs[10] = mk(1, OP_BC,   5'h0C, 4'h0, 0, 64'hD4, 0, 1, 1, 1, 1);
        vecs[11] = mk(1, OP_BC,   5'h0D, 4'h0, 0, 64'hD8, 1, 0, 1, 1, 0);
        vecs[12] = mk(1, OP_ADD,  5'h00, 4'h0, 0, 64'h200, 1, 0, 0, 1, 0);
        vecs[13] = mk(1, OP_ADD,  5'h00, 4'h0, 0, 64'h200, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, OP_B,    5'h00, 4'h0, 0, 64'h304, 1, 0, 1, 0, 0);

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset.p_valid", 32'(bus.p_valid), 32'd0);
        check("reset.p_taken", 32'(bus.p_taken), 32'd0);
        check("reset.mispredict", 32'(bus.mispredict), 32'd0);
        check("reset.mispredict_taken", 32'(bus.mispredict_taken), 32'd0);
        rst = 1'b0;

        fetch(64'h200, 1'b0, "first_fetch");

        for (int i = 0; i < 15; i++) resolve(vecs[i], $sformatf("vec%0d", i));

        fetch(64'h40,   1'b1, "pc40_ctr3");
        fetch(64'h1040, 1'b1, "alias_pc1040");
        fetch(64'h80,   1'b1, "pc80_ctr2");
        fetch(64'h84,   1'b0, "pc84_ctr0");
        fetch(64'h88,   1'b1, "pc88_ctr2");
        fetch(64'hC0,   1'b0, "pcC0_ctr0");
        fetch(64'hC4,   1'b1, "pcC4_ctr2");
        fetch(64'h304,  1'b0, "pc304_no_update");

        // f_valid low gates the prediction even for a strongly-taken entry
        bus.f_valid = 1'b0; bus.f_pc = 64'h40;
        @(posedge clk); #1;
        check("fvalid0.p_valid", 32'(bus.p_valid), 32'd0);
        check("fvalid0.p_taken", 32'(bus.p_taken), 32'd0);

        // Saturation at the top, then walk back down
        resolve(mk(1, OP_B,   5'h0, 4'h0, 0, 64'h40, 1, 1, 1, 0, 0), "sat_hi_B");
        resolve(mk(1, OP_CBZ, 5'h0, 4'h0, 0, 64'h40, 1, 0, 1, 1, 0), "sat_hi_nt1");
        fetch(64'h40, 1'b1, "sat_hi_ctr2");
        resolve(mk(1, OP_CBZ, 5'h0, 4'h0, 0, 64'h40, 1, 0, 1, 1, 0), "sat_hi_nt2");
        fetch(64'h40, 1'b0, "sat_hi_ctr1");

        // Saturation at the bottom
        resolve(mk(1, OP_CBZ, 5'h0, 4'h0, 0, 64'h84, 0, 0, 1, 0, 0), "sat_lo_nt");
        resolve(mk(1, OP_B,   5'h0, 4'h0, 0, 64'h84, 1, 1, 1, 0, 0), "sat_lo_B");
        fetch(64'h84, 1'b0, "sat_lo_ctr1");

        // Same index: predict sees the pre-update counter
        bus.f_valid = 1'b1; bus.f_pc = 64'h100;
        bus.x_valid = 1'b1; bus.x_opcode = OP_B; bus.x_pc = 64'h100; bus.x_predicted = 1'b0;
        @(posedge clk); #1;
        exp_br_cnt++; exp_mp_cnt++;
        check("same_idx.p_taken_old", 32'(bus.p_taken), 32'd0);
        check("same_idx.mispredict", 32'(bus.mispredict), 32'd1);
        bus.x_valid = 1'b0;
        @(posedge clk); #1;
        check("same_idx.p_taken_new", 32'(bus.p_taken), 32'd1);
        bus.f_valid = 1'b0;

`ifdef BRANCH_STATS_EN
        check("stat_branches", bus.stat_branches, 32'(exp_br_cnt));
        check("stat_mispredicts", bus.stat_mispredicts, 32'(exp_mp_cnt));
`endif

        // Reset while a mispredict is pending and an update is queued
        bus.x_valid = 1'b1; bus.x_opcode = OP_B; bus.x_pc = 64'h140; bus.x_predicted = 1'b0;
        @(posedge clk); #1;
        check("pend.mispredict", 32'(bus.mispredict), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst.mispredict", 32'(bus.mispredict), 32'd0);
        check("async_rst.mispredict_taken", 32'(bus.mispredict_taken), 32'd0);
        check("async_rst.p_valid", 32'(bus.p_valid), 32'd0);
`ifdef BRANCH_STATS_EN
        check("async_rst.stat_branches", bus.stat_branches, 32'd0);
        check("async_rst.stat_mispredicts", bus.stat_mispredicts, 32'd0);
`endif
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        fetch(64'h140, 1'b0, "post_rst_pc140");
        fetch(64'h100, 1'b0, "post_rst_pc100");
        fetch(64'h1040, 1'b0, "post_rst_pc1040");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch decision logic.
- Resolves LEGv8 branches (B, CBZ/CBNZ, B.cond) in the execute stage, as the existing decision logic does.
- Adds a PC-indexed table of saturating counters that gives fetch a registered taken/not-taken prediction.
- Reports mispredictions one cycle after resolve, so the pipeline can flush and redirect.

Parameters:
- PCWIDTH, 64, program-counter width.
- DEPTH, 64, number of predictor entries; power of two, at least 2.
- CTRBITS, 2, width of each saturating counter; at least 1.
- IDXBITS, $clog2(DEPTH), index width; derived, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- f_valid  in  1  fetch is requesting a prediction this cycle.
- f_pc  in  PCWIDTH  fetch PC.
- p_valid  out  1  prediction is valid; registered copy of f_valid.
- p_taken  out  1  registered prediction for the f_pc of the previous cycle.
- x_valid  in  1  an instruction is in execute.
- x_pc  in  PCWIDTH  PC of the execute instruction.
- x_opcode  in  `OPCODESIZE  opcode of the execute instruction.
- x_rd  in  `REGADDRSIZE  Rt field; condition code for B.cond.
- x_flags  in  `FLAGSIZE  NZVC, already forwarded.
- x_zero  in  1  ALU zero result, used by CBZ/CBNZ.
- x_predicted  in  1  the p_taken that travelled with this instruction.
- x_branch  out  1  combinational: the branch is actually taken.
- mispredict  out  1  registered one-cycle pulse.
- mispredict_taken  out  1  registered actual outcome that accompanies mispredict.

Behaviour:
- Index: idx = pc[IDXBITS+1:2]; word-aligned PCs, upper bits ignored (aliasing is allowed).
- Reset (asynchronous):
  - Every counter is set to weakly-not-taken, 2^(CTRBITS-1)-1.
  - p_valid, p_taken, mispredict and mispredict_taken are set to 0.
  - Reset asserted mid-operation discards any pending update and any pending mispredict.
- Predict path, latency 1:
  - On each edge, p_valid <= f_valid.
  - p_taken <= f_valid & MSB(ctr[idx(f_pc)]).
  - When f_valid=0, p_taken is 0.
- Branch classification (x_valid=1):
  - Uncond: opcode matches B_MASK/B_BITSET. Always taken.
  - Cbr: opcode matches CB_MASK/CB_BITSET. Taken when (~opcode[3] & x_zero) | (opcode[3] & ~x_zero).
  - Fbr: opcode matches BFLAG_MASK/BFLAG_BITSET. Taken per the condition encoding of x_rd[3:0]: 0x0 EQ through 0xD LE, standard NZVC meanings.
  - Condition codes 0xE and 0xF are never taken.
  - is_branch = Uncond | Cbr | Fbr.
  - x_branch = x_valid & is_branch & taken.
- Update, on an edge where x_valid & is_branch:
  - Taken: ctr[idx(x_pc)] increments, saturating at 2^CTRBITS-1.
  - Not taken: it decrements, saturating at 0.
  - Non-branches and x_valid=0 never modify the table.
- Same-cycle read/write to the same index: the prediction uses the pre-update value; the write takes effect on that edge (write-after-read).
- Mispredict, registered:
  - mispredict <= x_valid & (x_branch != x_predicted).
  - This includes a non-branch carrying x_predicted=1; in that case mispredict_taken=0.
  - mispredict_taken <= x_branch.
  - Both are 0 on any cycle not meeting the condition.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds two outputs.
  - stat_branches (32 bits) counts edges with x_valid & is_branch.
  - stat_mispredicts (32 bits) counts edges that set mispredict.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds: the condition-code constants 0x0–0xF; the counter reset value; and the B/CB/BFLAG mask and bitset constants, which stay in opcode.vh and are reused unchanged.
- The flag-condition evaluation (NZVC plus condition code to taken) becomes a sub-module, cond_eval, shared with the existing decision logic.
- The counter table stays inline.

Test Plan:
- Reset then f_valid=1 at any PC -> next cycle p_valid=1, p_taken=0 (with CTRBITS=2, every counter is 1).
- Resolve B at pc 0x40 twice, each time with x_predicted=0:
  - x_branch=1 each time.
  - mispredict=1 the cycle after each resolve.
  - The counter goes 1→2→3; fetching 0x40 afterwards gives p_taken=1.
- CBNZ with x_zero=0 (taken) and CBZ with x_zero=0 (not taken), each with x_predicted matching the outcome -> x_branch 1 then 0, mispredict stays 0.
- B.cond sweep:
  - flags NZVC=1001, codes 0xA (GE) and 0xB (LT) -> not taken / taken.
  - Codes 0xE and 0xF -> never taken.
- Same index: update-taken and predict at pc 0x100 in the same cycle from counter 1 -> p_taken=0 that cycle; an immediate re-fetch gives p_taken=1.
- rst asserted while a mispredict is pending -> mispredict=0 with no clock edge; the table returns to weakly-not-taken. With BRANCH_STATS_EN, the stat counters also read 0.
